// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes,
// instruction field values, datapath select encodings and decode helpers.
package ctrl_pkg;

    typedef enum logic [5:0] {
        ST_RST     = 6'd0,
        ST_FETCH   = 6'd1,
        ST_FWAIT   = 6'd2,
        ST_IRLD    = 6'd3,
        ST_DEC     = 6'd4,
        ST_R_EX    = 6'd5,
        ST_R_WB    = 6'd6,
        ST_MADDR   = 6'd7,
        ST_LRD     = 6'd8,
        ST_LWAIT   = 6'd9,
        ST_LWB     = 6'd10,
        ST_SWR     = 6'd11,
        ST_BEQ     = 6'd12,
        ST_BNE     = 6'd13,
        ST_I_EX    = 6'd14,
        ST_I_WB    = 6'd15,
        ST_JMP     = 6'd16,
        ST_EXC_OP  = 6'd17,
        ST_EXC_OVF = 6'd18,
        ST_EXC_VEC = 6'd19
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_EXC_A  = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic       a_write;
        logic       b_write;
        logic       epc_write;
        logic       reset_pc;
        logic       reset_a;
        logic       reset_b;
        logic       reset_epc;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_out_t;

    function automatic logic funct_is_alu(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    // Unrecognised functs fall back to ADD; they never reach write-back.
    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control/datapath bundle: instruction fields and ALU flags in, every
// datapath enable, select and clear strobe out, plus the debug state code.
interface multicycle_control_if;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;
    logic [5:0] Estado;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       AluSrcA;
    logic       AWrite;
    logic       BWrite;
    logic       EPCWrite;
    logic       ResetPC;
    logic       ResetA;
    logic       ResetB;
    logic       ResetEPC;
    logic [1:0] AluSrcB;
    logic [2:0] AluOp;
    logic [1:0] PCSource;

    modport master (
        input  OP, Funct, Zero, Overflow,
        output Estado, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               MemtoReg, RegDst, AluSrcA, AWrite, BWrite, EPCWrite,
               ResetPC, ResetA, ResetB, ResetEPC, AluSrcB, AluOp, PCSource
    );

    modport slave (
        output OP, Funct, Zero, Overflow,
        input  Estado, PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               MemtoReg, RegDst, AluSrcA, AWrite, BWrite, EPCWrite,
               ResetPC, ResetA, ResetB, ResetEPC, AluSrcB, AluOp, PCSource
    );
endinterface

// File: rtl/ctrl_wait_counter.sv
// 3-bit loadable down-counter used to stretch memory read states.
// done is high on the last wait cycle, i.e. when this cycle's decrement reaches zero.
module ctrl_wait_counter (
    input  logic       clk,
    input  logic       srst,
    input  logic       load,
    input  logic [2:0] value,
    output logic       done
);
    logic [2:0] count_reg;
    logic [2:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = value;
        end else if (count_reg != 3'd0) begin
            count_next = count_reg - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 3'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign done = (count_reg <= 3'd1);
endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core. Define CTRL_EXCEPTION_EN to
// build the illegal-instruction / overflow exception path (states 17..19).
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic                   Clock,
    input  logic                   Reset,
    multicycle_control_if.master   bus
);

`ifdef CTRL_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    localparam logic [2:0] WAIT_INIT = 3'(MEM_WAIT);

    state_t    state_reg;
    state_t    state_next;
    ctrl_out_t ctrl;
    logic      wait_load;
    logic      wait_done;
    logic      funct_arith;

    assign wait_load   = (state_reg == ST_FETCH) || (state_reg == ST_LRD);
    assign funct_arith = (bus.Funct == FN_ADD) || (bus.Funct == FN_SUB);

    ctrl_wait_counter u_wait (
        .clk   (Clock),
        .srst  (Reset),
        .load  (wait_load),
        .value (WAIT_INIT),
        .done  (wait_done)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= ST_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RST:   state_next = ST_FETCH;
            ST_FETCH: state_next = (WAIT_INIT == 3'd0) ? ST_IRLD : ST_FWAIT;
            ST_FWAIT: if (wait_done) state_next = ST_IRLD;
            ST_IRLD:  state_next = ST_DEC;
            ST_DEC: begin
                case (bus.OP)
                    OP_RTYPE:     state_next = ST_R_EX;
                    OP_LW, OP_SW: state_next = ST_MADDR;
                    OP_BEQ:       state_next = ST_BEQ;
                    OP_BNE:       state_next = ST_BNE;
                    OP_ADDI:      state_next = ST_I_EX;
                    OP_J:         state_next = ST_JMP;
                    default:      state_next = EXC_EN ? ST_EXC_OP : ST_FETCH;
                endcase
            end
            ST_R_EX: begin
                if (bus.Funct == FN_JR) begin
                    state_next = ST_FETCH;
                end else if (!funct_is_alu(bus.Funct)) begin
                    state_next = EXC_EN ? ST_EXC_OP : ST_FETCH;
                end else if (EXC_EN && funct_arith && bus.Overflow) begin
                    state_next = ST_EXC_OVF;
                end else begin
                    state_next = ST_R_WB;
                end
            end
            ST_MADDR:   state_next = (bus.OP == OP_SW) ? ST_SWR : ST_LRD;
            ST_LRD:     state_next = (WAIT_INIT == 3'd0) ? ST_LWB : ST_LWAIT;
            ST_LWAIT:   if (wait_done) state_next = ST_LWB;
            ST_I_EX:    state_next = (EXC_EN && bus.Overflow) ? ST_EXC_OVF : ST_I_WB;
            ST_EXC_OP,
            ST_EXC_OVF: state_next = ST_EXC_VEC;
            ST_R_WB, ST_LWB, ST_SWR, ST_BEQ, ST_BNE, ST_I_WB, ST_JMP,
            ST_EXC_VEC: state_next = ST_FETCH;
            default:    state_next = ST_RST;
        endcase
    end

    // Outputs follow the state register; only R_EX (AluOp, jr) and the
    // branch states (PCWrite) also look at the instruction/flag inputs.
    always_comb begin
        ctrl = '0;
        case (state_reg)
            ST_RST: begin
                ctrl.reset_pc  = 1'b1;
                ctrl.reset_a   = 1'b1;
                ctrl.reset_b   = 1'b1;
                ctrl.reset_epc = 1'b1;
            end
            ST_FETCH, ST_FWAIT: ctrl.mem_read = 1'b1;
            ST_IRLD: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_ALU;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_DEC: begin
                ctrl.a_write   = 1'b1;
                ctrl.b_write   = 1'b1;
                ctrl.alu_src_b = SRCB_IMM_SH2;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_R_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = funct_alu_op(bus.Funct);
                if (bus.Funct == FN_JR) begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCS_EXC_A;
                end
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            ST_MADDR, ST_I_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            ST_LRD, ST_LWAIT: begin
                ctrl.mem_read = 1'b1;
                ctrl.ior_d    = 1'b1;
            end
            ST_LWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_SWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.ior_d     = 1'b1;
            end
            ST_BEQ, ST_BNE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_source = PCS_ALUOUT;
                ctrl.pc_write  = (state_reg == ST_BEQ) ? bus.Zero : !bus.Zero;
            end
            ST_I_WB: ctrl.reg_write = 1'b1;
            ST_JMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            ST_EXC_OP, ST_EXC_OVF: begin
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALU_SUB;
                ctrl.epc_write = 1'b1;
            end
            ST_EXC_VEC: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_EXC_A;
            end
            default: ;
        endcase
    end

    assign bus.Estado   = state_reg;
    assign bus.PCWrite  = ctrl.pc_write;
    assign bus.IorD     = ctrl.ior_d;
    assign bus.MemRead  = ctrl.mem_read;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.RegWrite = ctrl.reg_write;
    assign bus.MemtoReg = ctrl.mem_to_reg;
    assign bus.RegDst   = ctrl.reg_dst;
    assign bus.AluSrcA  = ctrl.alu_src_a;
    assign bus.AWrite   = ctrl.a_write;
    assign bus.BWrite   = ctrl.b_write;
    assign bus.ResetPC  = ctrl.reset_pc;
    assign bus.ResetA   = ctrl.reset_a;
    assign bus.ResetB   = ctrl.reset_b;
    assign bus.ResetEPC = ctrl.reset_epc;
    assign bus.AluSrcB  = ctrl.alu_src_b;
    assign bus.AluOp    = ctrl.alu_op;
    assign bus.PCSource = ctrl.pc_source;
`ifdef CTRL_EXCEPTION_EN
    assign bus.EPCWrite = ctrl.epc_write;
`else
    assign bus.EPCWrite = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions followed by
// random ones, each checked cycle by cycle against an instruction-level model.
module tb_multicycle_control;

    localparam int MW = 1;
`ifdef CTRL_EXCEPTION_EN
    localparam bit EXC = 1'b1;
`else
    localparam bit EXC = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   exp_q[$];

    multicycle_control_if bus ();

    multicycle_control #(.MEM_WAIT(MW)) dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic is_alu(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] f);
        case (f)
            6'h22:   return 3'd1;
            6'h24:   return 3'd2;
            6'h25:   return 3'd3;
            6'h2A:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Instruction-level model: the full list of state codes one instruction visits.
    task automatic build(input logic [5:0] op, input logic [5:0] f, input logic ovf);
        exp_q.delete();
        exp_q.push_back(1);
        for (int k = 0; k < MW; k++) exp_q.push_back(2);
        exp_q.push_back(3);
        exp_q.push_back(4);
        case (op)
            6'h00: begin
                exp_q.push_back(5);
                if (f == 6'h08) begin
                end else if (!is_alu(f)) begin
                    if (EXC) begin exp_q.push_back(17); exp_q.push_back(19); end
                end else if (EXC && ovf && (f == 6'h20 || f == 6'h22)) begin
                    exp_q.push_back(18); exp_q.push_back(19);
                end else begin
                    exp_q.push_back(6);
                end
            end
            6'h23: begin
                exp_q.push_back(7);
                exp_q.push_back(8);
                for (int k = 0; k < MW; k++) exp_q.push_back(9);
                exp_q.push_back(10);
            end
            6'h2B: begin exp_q.push_back(7); exp_q.push_back(11); end
            6'h04: exp_q.push_back(12);
            6'h05: exp_q.push_back(13);
            6'h08: begin
                exp_q.push_back(14);
                if (EXC && ovf) begin exp_q.push_back(18); exp_q.push_back(19); end
                else exp_q.push_back(15);
            end
            6'h02: exp_q.push_back(16);
            default: if (EXC) begin exp_q.push_back(17); exp_q.push_back(19); end
        endcase
    endtask

    // {ResetPC, PCWrite, MemRead, IorD, MemWrite, IRWrite, RegWrite, MemtoReg, RegDst, EPCWrite}
    function automatic logic [9:0] exp_strobes(input int s, input logic [5:0] f, input logic z);
        logic pcw;
        pcw = (s == 3) || (s == 16) || (s == 19) || (s == 5 && f == 6'h08) ||
              (s == 12 && z) || (s == 13 && !z);
        return {s == 0, pcw, (s == 1 || s == 2 || s == 8 || s == 9),
                (s == 8 || s == 9 || s == 11), s == 11, s == 3,
                (s == 6 || s == 10 || s == 15), s == 10, s == 6, (s == 17 || s == 18)};
    endfunction

    function automatic logic [9:0] obs_strobes();
        return {bus.ResetPC, bus.PCWrite, bus.MemRead, bus.IorD, bus.MemWrite,
                bus.IRWrite, bus.RegWrite, bus.MemtoReg, bus.RegDst, bus.EPCWrite};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                             input logic ovf, input int reset_at);
        int n;
        build(op, f, ovf);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) begin
                bus.OP = op; bus.Funct = f; bus.Zero = z; bus.Overflow = ovf;
            end
            #1;
            check("estado", 32'(bus.Estado), 32'(exp_q[i]));
            check("strobes", 32'(obs_strobes()), 32'(exp_strobes(exp_q[i], f, z)));
            if (exp_q[i] == 5 && is_alu(f)) check("aluop_r", 32'(bus.AluOp), 32'(alu_of(f)));
            if (exp_q[i] == 12 || exp_q[i] == 13) check("pcsource_br", 32'(bus.PCSource), 32'd1);
            if (exp_q[i] == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                #1;
                check("estado_rst", 32'(bus.Estado), 32'd0);
                check("strobes_rst", 32'(obs_strobes()), 32'(exp_strobes(0, f, z)));
                rst = 1'b0;
                $display("instr op=%h funct=%h zero=%b ovf=%b reset at state %0d", op, f, z, ovf, reset_at);
                return;
            end
        end
        $display("instr op=%h funct=%h zero=%b ovf=%b states=%0d", op, f, z, ovf, n);
    endtask

    initial begin
        logic [5:0] ops[9];
        logic [5:0] fns[8];
        ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F, 6'h0F};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h08, 6'h00, 6'h3A};
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.OP = 6'h00; bus.Funct = 6'h20; bus.Zero = 1'b0; bus.Overflow = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("estado_reset", 32'(bus.Estado), 32'd0);
            check("strobes_reset", 32'(obs_strobes()), 32'(exp_strobes(0, 6'h00, 1'b0)));
        end
        rst = 1'b0;

        run_instr(6'h00, 6'h20, 1'b0, 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b1, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, -1);
        run_instr(6'h08, 6'h00, 1'b0, 1'b1, -1);
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 9);
        run_instr(6'h00, 6'h22, 1'b0, 1'b1, -1);
        run_instr(6'h00, 6'h08, 1'b0, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, 1'b1, -1);

        for (int t = 0; t < 40; t++) begin
            run_instr(ops[$urandom_range(0, 8)], fns[$urandom_range(0, 7)],
                      1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), -1);
        end

        @(negedge clk);
        #1;
        check("estado_final", 32'(bus.Estado), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
